ahb_ram_slave: RTL and testbench

AHB-Lite scratchpad slave that terminates the single output port of the AHB fanout stage. It holds a byte-writable 32-bit word array and registers each address phase. It completes OKAY transfers with optional inserted wait states, and answers illegal accesses with the standard two-cycle ERROR response.

---
 rtl/ahb_ram_pkg.sv | 29 ++
 rtl/ahb_ram_slave_if.sv | 24 ++
 rtl/ahb_ram_array.sv | 28 ++
 rtl/ahb_ram_slave.sv | 120 ++++++++++++
 tb/tb_ahb_ram_slave.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/ahb_ram_pkg.sv
// Shared AHB-Lite encodings, FSM state type and byte-enable helper for the
// scratchpad RAM slave.
package ahb_ram_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {IDLE, DATA, ERR1, ERR2} state_t;

    // Lane mask for a naturally aligned access; illegal sizes fall to all lanes
    // and are rejected elsewhere.
    function automatic logic [3:0] be_gen(input logic [2:0] size, input logic [1:0] lsb);
        case (size)
            HSIZE_BYTE: be_gen = 4'b0001 << lsb;
            HSIZE_HALF: be_gen = 4'b0011 << lsb;
            default:    be_gen = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/ahb_ram_slave_if.sv
// AHB-Lite slave-side bus bundle between the fanout stage and the RAM slave.
interface ahb_ram_slave_if;
    logic        auto_in_hready;
    logic        auto_in_hreadyout;
    logic [1:0]  auto_in_htrans;
    logic [2:0]  auto_in_hsize;
    logic        auto_in_hwrite;
    logic [30:0] auto_in_haddr;
    logic [31:0] auto_in_hwdata;
    logic        auto_in_hresp;
    logic [31:0] auto_in_hrdata;

    modport master (
        output auto_in_hready, auto_in_htrans, auto_in_hsize, auto_in_hwrite,
               auto_in_haddr, auto_in_hwdata,
        input  auto_in_hreadyout, auto_in_hresp, auto_in_hrdata
    );

    modport slave (
        input  auto_in_hready, auto_in_htrans, auto_in_hsize, auto_in_hwrite,
               auto_in_haddr, auto_in_hwdata,
        output auto_in_hreadyout, auto_in_hresp, auto_in_hrdata
    );
endinterface

// File: rtl/ahb_ram_array.sv
// DEPTH x (NUM_LANES*LANE_W) storage: per-lane write enables, asynchronous read.
module ahb_ram_array #(
    parameter int DEPTH     = 1024,
    parameter int NUM_LANES = 4,
    parameter int LANE_W    = 8,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic                              clock,
    input  logic                              we,
    input  logic [AW-1:0]                     addr,
    input  logic [NUM_LANES-1:0]              be,
    input  logic [NUM_LANES-1:0][LANE_W-1:0]  wdata,
    output logic [NUM_LANES-1:0][LANE_W-1:0]  rdata
);

    // One independent column per byte lane so each lane has a single writer.
    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        logic [LANE_W-1:0] mem [DEPTH];

        always_ff @(posedge clock) begin
            if (we && be[l])
                mem[addr] <= wdata[l];
        end

        assign rdata[l] = mem[addr];
    end

endmodule

// File: rtl/ahb_ram_slave.sv
// AHB-Lite scratchpad slave: registered address phase, OKAY/ERROR responses.
// Define AHB_RAM_WAIT_EN to insert WAIT_CYCLES wait states per OKAY data phase.
import ahb_ram_pkg::*;

module ahb_ram_slave #(
    parameter int          DEPTH       = 1024,
    parameter logic [30:0] BASE_ADDR   = 31'h0000_0000,
    parameter int          WAIT_CYCLES = 1
) (
    input  logic       clock,
    input  logic       reset_n,
    ahb_ram_slave_if.slave bus
);

    localparam int          AW     = $clog2(DEPTH);
    localparam logic [32:0] BASE33 = {2'b00, BASE_ADDR};

    state_t          state, state_nxt;
    logic [AW-1:0]   idx_q;
    logic [3:0]      be_q;
    logic            wr_q;
    logic            ready_q, ready_nxt;
    logic            resp_q, resp_nxt;
    logic [3:0]      cnt;
    logic            pend_nxt;
    logic            accept, err_in, misalign, below, above, we;
    logic [32:0]     diff;
    logic [31:0]     rdata;

    // The slave only samples an address phase when the bus and itself are ready.
    assign accept = bus.auto_in_hready & bus.auto_in_htrans[1] & ready_q;

    assign diff     = {2'b00, bus.auto_in_haddr} - BASE33;
    assign below    = diff[32];
    assign above    = |diff[31:AW+2];
    assign misalign = (bus.auto_in_hsize == HSIZE_HALF && bus.auto_in_haddr[0]) ||
                      (bus.auto_in_hsize == HSIZE_WORD && bus.auto_in_haddr[1:0] != 2'b00);
    assign err_in   = below | above | (bus.auto_in_hsize > HSIZE_WORD) | misalign;

    always_comb begin
        state_nxt = state;
        we        = 1'b0;
        unique case (state)
            IDLE, ERR2: begin
                if (accept) state_nxt = err_in ? ERR1 : DATA;
                else        state_nxt = IDLE;
            end
            DATA: begin
                if (cnt == 4'd0) begin
                    we = wr_q;
                    if (accept) state_nxt = err_in ? ERR1 : DATA;
                    else        state_nxt = IDLE;
                end
            end
            ERR1:    state_nxt = ERR2;
            default: state_nxt = IDLE;
        endcase
        ready_nxt = (state_nxt != ERR1) && !pend_nxt;
        resp_nxt  = (state_nxt == ERR1 || state_nxt == ERR2) ? HRESP_ERROR : HRESP_OKAY;
    end

`ifdef AHB_RAM_WAIT_EN
    logic [3:0] cnt_nxt;

    always_comb begin
        cnt_nxt = cnt;
        if (accept && !err_in) cnt_nxt = 4'(WAIT_CYCLES);
        else if (cnt != 4'd0)  cnt_nxt = cnt - 4'd1;
        pend_nxt = (state_nxt == DATA) && (cnt_nxt != 4'd0);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) cnt <= 4'd0;
        else          cnt <= cnt_nxt;
    end
`else
    logic unused_wait;
    assign cnt         = 4'd0;
    assign pend_nxt    = 1'b0;
    assign unused_wait = ^4'(WAIT_CYCLES);
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            ready_q <= 1'b1;
            resp_q  <= HRESP_OKAY;
            idx_q   <= '0;
            be_q    <= '0;
            wr_q    <= 1'b0;
        end else begin
            state   <= state_nxt;
            ready_q <= ready_nxt;
            resp_q  <= resp_nxt;
            if (accept) begin
                idx_q <= diff[AW+1:2];
                be_q  <= be_gen(bus.auto_in_hsize, bus.auto_in_haddr[1:0]);
                wr_q  <= bus.auto_in_hwrite;
            end
        end
    end

    ahb_ram_array #(.DEPTH(DEPTH)) u_array (
        .clock (clock),
        .we    (we),
        .addr  (idx_q),
        .be    (be_q),
        .wdata (bus.auto_in_hwdata),
        .rdata (rdata)
    );

    // Read data is only driven in the completing cycle of a read data phase.
    assign bus.auto_in_hreadyout = ready_q;
    assign bus.auto_in_hresp     = resp_q;
    assign bus.auto_in_hrdata    = (state == DATA && ready_q && !wr_q) ? rdata : 32'h0;

    logic unused_ok;
    assign unused_ok = &{1'b0, bus.auto_in_htrans[0], diff[1:0]};

endmodule

// File: tb/tb_ahb_ram_slave.sv
// Directed scoreboard bench for ahb_ram_slave; expectations follow AHB_RAM_WAIT_EN.
`define CHK(tag, obs, exp) \
    begin \
        checks++; \
        assert ((obs) === (exp)) else begin \
            failures++; \
            $error("FAIL %s observed=%0h expected=%0h", tag, (obs), (exp)); \
        end \
    end

module tb_ahb_ram_slave;
    import ahb_ram_pkg::*;

    localparam int          DEPTH = 64;
    localparam logic [30:0] BASE  = 31'h0;
`ifdef AHB_RAM_WAIT_EN
    localparam int EXP_WAIT = 3;
`else
    localparam int EXP_WAIT = 0;
`endif

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    ahb_ram_slave_if bus ();
    assign bus.auto_in_hready = bus.auto_in_hreadyout;

    ahb_ram_slave #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_CYCLES(3)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    typedef struct {
        int          id;
        logic        err;
        logic        chk;
        logic [31:0] data;
        int          waits;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] model [int];
    bit          pend = 1'b0;
    int          waits_seen = 0;
    int          id_n = 0;
    int          checks = 0;
    int          failures = 0;

    // One bus cycle: inspect the pending data phase at the falling edge.
    task automatic tick(output bit rdy);
        exp_t e;
        @(negedge clock);
        rdy = bus.auto_in_hreadyout;
        if (pend) begin
            if (!rdy) begin
                waits_seen++;
                `CHK("stall_hresp", bus.auto_in_hresp, sbq[0].err)
                if (waits_seen > 32) begin
                    failures++;
                    $display("FAIL stall_timeout id=%0d observed=%0d expected=%0d",
                             sbq[0].id, waits_seen, sbq[0].waits);
                    $fatal(1, "stalled data phase");
                end
            end else begin
                e = sbq.pop_front();
                `CHK("done_hresp", bus.auto_in_hresp, e.err)
                if (e.chk) `CHK("rdata", bus.auto_in_hrdata, e.data)
                `CHK("wait_count", waits_seen, e.waits)
                pend       = 1'b0;
                waits_seen = 0;
            end
        end
        @(posedge clock);
    endtask

    task automatic issue(input bit wr, input logic [2:0] size, input logic [30:0] addr,
                         input logic [31:0] wdata, input bit exp_err);
        exp_t e;
        bit   rdy;
        int   widx;
        int   lo, n;
        e.id    = id_n++;
        e.err   = exp_err;
        e.chk   = !wr && !exp_err;
        e.data  = 32'h0;
        e.waits = exp_err ? 1 : EXP_WAIT;
        if (!exp_err) begin
            widx = int'((addr - BASE) >> 2);
            lo   = int'(addr[1:0]);
            n    = 1 << size;
            if (wr) begin
                if (!model.exists(widx)) model[widx] = 32'h0;
                for (int k = 0; k < 4; k++)
                    if (k >= lo && k < lo + n) model[widx][8*k +: 8] = wdata[8*k +: 8];
            end else begin
                e.data = model[widx];
            end
        end
        bus.auto_in_htrans = HTRANS_NONSEQ;
        bus.auto_in_hwrite = wr;
        bus.auto_in_hsize  = size;
        bus.auto_in_haddr  = addr;
        do tick(rdy); while (!rdy);
        #1;
        sbq.push_back(e);
        pend               = 1'b1;
        waits_seen         = 0;
        bus.auto_in_hwdata = wdata;
        bus.auto_in_htrans = HTRANS_IDLE;
    endtask

    task automatic flush();
        bit rdy;
        bus.auto_in_htrans = HTRANS_IDLE;
        while (pend) tick(rdy);
        #1;
    endtask

    initial begin
        bus.auto_in_htrans = HTRANS_IDLE;
        bus.auto_in_hsize  = HSIZE_WORD;
        bus.auto_in_hwrite = 1'b0;
        bus.auto_in_haddr  = 31'h0;
        bus.auto_in_hwdata = 32'h0;

        repeat (2) @(posedge clock);
        @(negedge clock);
        `CHK("rst_hreadyout", bus.auto_in_hreadyout, 1'b1)
        `CHK("rst_hresp", bus.auto_in_hresp, 1'b0)
        `CHK("rst_hrdata", bus.auto_in_hrdata, 32'h0)
        reset_n = 1'b1;
        @(posedge clock); #1;

        // Word write immediately followed by a read of the same word.
        issue(1, HSIZE_WORD, 31'h10, 32'hDEAD_BEEF, 0);
        issue(0, HSIZE_WORD, 31'h10, 32'h0, 0);
        flush();

        // Single byte lane over a zeroed word.
        issue(1, HSIZE_WORD, 31'h0,  32'h1234_5678, 0);
        issue(1, HSIZE_WORD, 31'h10, 32'h0, 0);
        issue(1, HSIZE_BYTE, 31'h13, 32'hA5A5_A5A5, 0);
        issue(0, HSIZE_WORD, 31'h10, 32'h0, 0);
        flush();
        `CHK("byte_lane_word", model[4], 32'hA500_0000)

        // Misaligned halfword write must not touch the array.
        issue(1, HSIZE_HALF, 31'h11, 32'hFFFF_FFFF, 1);
        issue(0, HSIZE_WORD, 31'h10, 32'h0, 0);
        flush();

        // One past the end, then a legal read straight after the ERROR.
        issue(0, HSIZE_WORD, 31'(4 * DEPTH), 32'h0, 1);
        issue(0, HSIZE_WORD, 31'h0, 32'h0, 0);
        flush();

        // Last legal word and an oversized transfer.
        issue(1, HSIZE_WORD, 31'(4 * DEPTH - 4), 32'hCAFE_F00D, 0);
        issue(0, HSIZE_WORD, 31'(4 * DEPTH - 4), 32'h0, 0);
        issue(0, 3'd3, 31'h10, 32'h0, 1);
        flush();

        // Upper halfword lane.
        issue(1, HSIZE_WORD, 31'h20, 32'h1111_1111, 0);
        issue(1, HSIZE_HALF, 31'h22, 32'hBEEF_0000, 0);
        issue(0, HSIZE_WORD, 31'h20, 32'h0, 0);
        flush();

        @(negedge clock);
        `CHK("idle_hreadyout", bus.auto_in_hreadyout, 1'b1)
        `CHK("idle_hresp", bus.auto_in_hresp, 1'b0)
        `CHK("idle_hrdata", bus.auto_in_hrdata, 32'h0)
        @(posedge clock); #1;

        // BUSY is not a transfer: no data phase follows.
        bus.auto_in_htrans = HTRANS_BUSY;
        bus.auto_in_hwrite = 1'b0;
        bus.auto_in_haddr  = 31'h10;
        @(posedge clock); #1;
        bus.auto_in_htrans = HTRANS_IDLE;
        @(negedge clock);
        `CHK("busy_hreadyout", bus.auto_in_hreadyout, 1'b1)
        `CHK("busy_hresp", bus.auto_in_hresp, 1'b0)
        `CHK("busy_hrdata", bus.auto_in_hrdata, 32'h0)
        @(posedge clock); #1;

        // Reset in the middle of a read data phase.
        issue(0, HSIZE_WORD, 31'h10, 32'h0, 0);
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        `CHK("midrst_hreadyout", bus.auto_in_hreadyout, 1'b1)
        `CHK("midrst_hresp", bus.auto_in_hresp, 1'b0)
        `CHK("midrst_hrdata", bus.auto_in_hrdata, 32'h0)
        pend = 1'b0;
        waits_seen = 0;
        sbq.delete();
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock); #1;

        // Array contents survive reset.
        issue(0, HSIZE_WORD, 31'h10, 32'h0, 0);
        issue(0, HSIZE_WORD, 31'h0,  32'h0, 0);
        flush();
        `CHK("sb_empty", sbq.size(), 0)

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
